// File: rtl/echo_app_if.sv
// echo_app_if: OUT/IN byte streams and sleep flag between the USB side and echo_app.
interface echo_app_if;
  logic [7:0] out_data_i;
  logic out_valid_i;
  logic out_ready_o;
  logic [7:0] in_data_o;
  logic in_valid_o;
  logic in_ready_i;
  logic sleep_o;
  modport slave(input out_data_i, out_valid_i, in_ready_i, output out_ready_o, in_data_o, in_valid_o, sleep_o);
  modport master(output out_data_i, out_valid_i, in_ready_i, input out_ready_o, in_data_o, in_valid_o, sleep_o);
endinterface

// File: rtl/echo_app.sv
// echo_app: echoes host bytes back through a FIFO, optionally upper-casing, and flags long idle periods.
module echo_app #(
  parameter int FIFO_DEPTH = 16,
  parameter bit UPPERCASE = 1,
  parameter int SLEEP_CYCLES = 2000
) (
  input logic clk_i,
  input logic rst_i,
  echo_app_if.slave bus
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [19:0] SLP = 20'(SLEEP_CYCLES);
  typedef enum logic {ACTIVE, SLEEP} state_t;
  state_t state, state_nxt;
  logic [7:0] mem [FIFO_DEPTH];
  logic [AW:0] wr_ptr, rd_ptr, wr_nxt, rd_nxt, occ_nxt;
  logic [19:0] idle, idle_nxt;
  logic [7:0] din;
  logic push, pop, ready, nonempty, slp, lower;
  assign nonempty = wr_ptr != rd_ptr;
  assign push = bus.out_valid_i & ready;
  assign pop = nonempty & bus.in_ready_i;
  assign lower = bus.out_data_i >= 8'h61 && bus.out_data_i <= 8'h7A;
  assign din = (UPPERCASE && lower) ? bus.out_data_i - 8'h20 : bus.out_data_i;
  assign wr_nxt = wr_ptr + (AW+1)'(push);
  assign rd_nxt = rd_ptr + (AW+1)'(pop);
  // Occupancy of FIFO_DEPTH sets the top bit, which is exactly the full condition.
  assign occ_nxt = wr_nxt - rd_nxt;
  assign idle_nxt = (push | nonempty) ? '0 : (idle == SLP ? idle : idle + 20'd1);
  assign state_nxt = (state == ACTIVE) ? (idle_nxt == SLP ? SLEEP : ACTIVE) : ((push | nonempty) ? ACTIVE : SLEEP);
  assign bus.out_ready_o = ready;
  assign bus.in_valid_o = nonempty;
  assign bus.in_data_o = mem[rd_ptr[AW-1:0]];
  assign bus.sleep_o = slp;
  always_ff @(posedge clk_i) begin
    if (push) mem[wr_ptr[AW-1:0]] <= din;
  end
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      ready <= 1'b0;
      idle <= '0;
      state <= ACTIVE;
      slp <= 1'b0;
    end else begin
      wr_ptr <= wr_nxt;
      rd_ptr <= rd_nxt;
      ready <= ~occ_nxt[AW];
      idle <= idle_nxt;
      state <= state_nxt;
      slp <= state_nxt == SLEEP;
    end
  end
endmodule

// File: doc/echo_app.md
ECHO_APP -- requirements
Module: echo_app

Interface
- REQ-001 Parameter FIFO_DEPTH, default 16; byte-buffer depth, power of two, 2..256.
- REQ-002 Parameter UPPERCASE, default 1; 1 maps ASCII 'a'..'z' to upper case, 0 passes bytes unchanged.
- REQ-003 Parameter SLEEP_CYCLES, default 2000; idle cycles before sleep_o asserts, 1..2^20-1.
- REQ-004 clk_i  input  1  application clock; all state on rising edge.
- REQ-005 rst_i  input  1  asynchronous reset, active-high.
- REQ-006 out_data_i  input  8  byte received from USB host (OUT endpoint).
- REQ-007 out_valid_i  input  1  out_data_i valid.
- REQ-008 out_ready_o  output  1  block accepts out_data_i this cycle.
- REQ-009 in_data_o  output  8  byte to send to USB host (IN endpoint).
- REQ-010 in_valid_o  output  1  in_data_o valid.
- REQ-011 in_ready_i  input  1  USB side accepts in_data_o this cycle.
- REQ-012 sleep_o  output  1  block idle; top level may allow suspend.

Function
- REQ-013 Push: out_valid_i & out_ready_o on a rising edge writes one byte to FIFO tail.
- REQ-014 Pop: in_valid_o & in_ready_i on a rising edge removes one byte from FIFO head.
- REQ-015 Transform at push: UPPERCASE=1 and byte in 8'h61..8'h7A -> store byte - 8'h20; all other bytes stored unchanged.
- REQ-016 Storage: memory FIFO_DEPTH x 8; read/write pointers log2(FIFO_DEPTH)+1 bits, wrap modulo 2*FIFO_DEPTH; full = MSBs differ and lower bits equal; empty = pointers equal.
- REQ-017 in_valid_o = not empty; in_data_o = memory[head]; byte pushed at edge N visible with in_valid_o=1 after edge N (one-cycle latency from empty).
- REQ-018 in_data_o stable and in_valid_o held high until popped; no byte dropped or duplicated.
- REQ-019 out_ready_o registered: after each edge equals 1 iff occupancy after that edge < FIFO_DEPTH.
- REQ-020 Simultaneous push and pop: both take effect, occupancy unchanged; legal when full only if out_ready_o was already 1 (no push while out_ready_o=0).
- REQ-021 Pop while empty impossible (in_valid_o=0); push while full impossible (out_ready_o=0); out_valid_i during out_ready_o=0 ignored, byte not consumed.
- REQ-022 Byte order preserved across pointer wrap-around; FIFO_DEPTH bytes fill to exactly full.
- REQ-023 Idle counter, 20 bits, saturating: cleared on any edge with push, pop, or FIFO non-empty; otherwise increments by 1 until it equals SLEEP_CYCLES.
- REQ-024 sleep_o registered: 1 iff idle counter == SLEEP_CYCLES; deasserts the edge after any push (counter cleared).
- REQ-025 Two-state activity machine ACTIVE/SLEEP: ACTIVE->SLEEP when counter reaches SLEEP_CYCLES; SLEEP->ACTIVE on push or FIFO non-empty; sleep_o=1 only in SLEEP.

Reset
- REQ-026 rst_i=1 asynchronously forces: pointers 0, FIFO empty, in_valid_o=0, out_ready_o=0, idle counter 0, state ACTIVE, sleep_o=0.
- REQ-027 First rising edge with rst_i=0 sets out_ready_o=1; memory contents need no reset.
- REQ-028 rst_i asserted mid-transfer discards all buffered bytes; no partial handshake completes on that edge.

Verification
- REQ-029 Reset release, push 8'h61 ('a') with in_ready_i=0 -> next cycle in_valid_o=1, in_data_o=8'h41; held until in_ready_i=1, then in_valid_o=0.
- REQ-030 Push 16 bytes 8'h00..8'h0F, in_ready_i=0 -> out_ready_o=0 after 16th push; 17th byte offered not consumed; drain yields 8'h00..8'h0F in order.
- REQ-031 Full FIFO, out_valid_i=1 and in_ready_i=1 continuously for 40 cycles, incrementing data -> one byte in and out per cycle after out_ready_o returns, order preserved through multiple wraps, occupancy never exceeds 16.
- REQ-032 UPPERCASE=1, push 8'h60, 8'h7A, 8'h7B, 8'h41 -> output 8'h60, 8'h5A, 8'h7B, 8'h41; UPPERCASE=0 -> unchanged.
- REQ-033 SLEEP_CYCLES=10, no traffic after reset -> sleep_o=1 after 10 idle edges; push one byte -> sleep_o=0 next edge, stays 0 until byte popped plus 10 idle edges.
- REQ-034 Assert rst_i asynchronously with 5 bytes buffered -> in_valid_o, out_ready_o, sleep_o drop to 0 immediately without clock; after release no old byte appears.
